// File: rtl/mul32_seq.sv
// Iterative multiplier: one partial-product step per clock, full 2*WIDTH-bit product.
// Define MUL32_SIGNED_EN for two's-complement operands (radix-2 Booth); default is unsigned.
module mul32_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q;
  logic              busy_dly_q;
  logic [WIDTH-1:0]  m_q;
  logic [WIDTH:0]    acc_q;
  logic [WIDTH-1:0]  q_q;
  logic [CntW-1:0]   cnt_q;

  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    acc_step;
  logic [WIDTH-1:0]  q_step;

`ifdef MUL32_SIGNED_EN
  logic              qm1_q;
  logic [WIDTH:0]    m_ext;

  assign m_ext = {m_q[WIDTH-1], m_q};
`endif

  always_comb begin
    sum = acc_q;
`ifdef MUL32_SIGNED_EN
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_ext;
      2'b10:   sum = acc_q - m_ext;
      default: ;
    endcase
    acc_step = {sum[WIDTH], sum[WIDTH:1]};
`else
    // acc[WIDTH] is always 0 between steps, so bit WIDTH of sum is the carry.
    if (q_q[0]) sum = acc_q + {1'b0, m_q};
    acc_step = {1'b0, sum[WIDTH:1]};
`endif
    q_step = {sum[0], q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      busy_dly_q <= 1'b0;
      m_q        <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      cnt_q      <= '0;
`ifdef MUL32_SIGNED_EN
      qm1_q      <= 1'b0;
`endif
    end else begin
      busy_dly_q <= (state_q == StRun);
      // start wins in every state; a restart during RUN silently drops the old job.
      if (start) begin
        state_q <= StRun;
        m_q     <= src1;
        acc_q   <= '0;
        q_q     <= src2;
        cnt_q   <= CntW'(WIDTH - 1);
`ifdef MUL32_SIGNED_EN
        qm1_q   <= 1'b0;
`endif
      end else if (state_q == StRun) begin
        acc_q <= acc_step;
        q_q   <= q_step;
`ifdef MUL32_SIGNED_EN
        qm1_q <= q_q[0];
`endif
        if (cnt_q == '0) begin
          state_q <= StIdle;
        end else begin
          cnt_q <= cnt_q - CntW'(1);
        end
      end
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = !busy && busy_dly_q;
  assign prod_hi = acc_q[WIDTH-1:0];
  assign prod_lo = q_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq against an arithmetic reference product.
// Follows MUL32_SIGNED_EN to pick the signed or unsigned reference.
module tb_mul32_seq;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  mul32_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .src1    (src1),
    .src2    (src2),
    .prod_hi (prod_hi),
    .prod_lo (prod_lo),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL32_SIGNED_EN
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    return {32'b0, a} * {32'b0, b};
`endif
  endfunction

  // Returns at the first negedge after the start edge (cycle 1 of the job).
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    src1  = a;
    src2  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in cycle 1; returns in the done cycle (or after the bound expires).
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 1;
    bcnt = 0;
    while (!done && cyc < 80) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    start = 1'b0;
    src1  = '0;
    src2  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if ({prod_hi, prod_lo} !== 64'h0) begin
      errors++; $display("FAIL reset_prod got %h_%h want 0", prod_hi, prod_lo);
    end
    n_rst = 1'b1;
  endtask

  task automatic test_basic;
    int cyc;
    int bcnt;
    launch(32'd3, 32'd5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_on got %b want 1", busy); end
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 33) begin errors++; $display("FAIL basic_latency got %0d want 33", cyc); end
    checks++;
    if (bcnt !== 32) begin errors++; $display("FAIL basic_busy_cycles got %0d want 32", bcnt); end
    checks++;
    if ({prod_hi, prod_lo} !== 64'h0000_0000_0000_000F) begin
      errors++; $display("FAIL basic_prod got %h_%h want 00000000_0000000f", prod_hi, prod_lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
    repeat (3) @(negedge clk);
    checks++;
    if ({prod_hi, prod_lo} !== 64'hF || busy !== 1'b0) begin
      errors++; $display("FAIL basic_hold got %h_%h busy %b want 0_f busy 0", prod_hi, prod_lo, busy);
    end
  endtask

  task automatic test_products;
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [63:0] exp_p;
    int cyc;
    int bcnt;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
    va[1] = 32'hFFFF_FFFD; vb[1] = 32'd7;
    va[2] = 32'h8000_0000; vb[2] = 32'h8000_0000;
    va[3] = 32'd0;         vb[3] = 32'h1234_5678;
    for (int i = 4; i < 8; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
    end
    for (int i = 0; i < 8; i++) begin
      exp_p = ref_prod(va[i], vb[i]);
      launch(va[i], vb[i]);
      wait_done(cyc, bcnt);
      checks++;
      if (cyc !== 33 || {prod_hi, prod_lo} !== exp_p) begin
        errors++;
        $display("FAIL prod_%0d %h*%h got %h_%h at cycle %0d want %h at cycle 33",
                 i, va[i], vb[i], prod_hi, prod_lo, cyc, exp_p);
      end
    end
  endtask

  task automatic test_abort;
    int dones;
    int cyc;
    int bcnt;
    dones = 0;
    launch(32'h1234, 32'h10);
    repeat (9) begin
      @(negedge clk);
      if (done) dones++;
    end
    launch(32'd2, 32'h8000_0000);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 33 || {prod_hi, prod_lo} !== ref_prod(32'd2, 32'h8000_0000)) begin
      errors++;
      $display("FAIL abort_prod got %h_%h at cycle %0d want %h at cycle 33",
               prod_hi, prod_lo, cyc, ref_prod(32'd2, 32'h8000_0000));
    end
    if (done) dones++;
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL abort_done_count got %0d want 1", dones); end
  endtask

  task automatic test_reset_mid;
    int dones;
    int cyc;
    int bcnt;
    dones = 0;
    launch($urandom | 32'h1, $urandom | 32'h1);
    repeat (14) @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {prod_hi, prod_lo} !== 64'h0) begin
      errors++;
      $display("FAIL midreset_clear got busy %b done %b prod %h_%h want all 0",
               busy, done, prod_hi, prod_lo);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", dones); end
    launch(32'd7, 32'd9);
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 33 || {prod_hi, prod_lo} !== 64'h3F) begin
      errors++; $display("FAIL midreset_after got %h_%h at cycle %0d want 0_3f", prod_hi, prod_lo, cyc);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    logic [31:0] b;
    int cyc;
    int bcnt;
    a = $urandom;
    b = $urandom;
    launch(a, b);
    wait_done(cyc, bcnt);
    checks++;
    if (done !== 1'b1 || {prod_hi, prod_lo} !== ref_prod(a, b)) begin
      errors++;
      $display("FAIL b2b_first got done %b prod %h_%h want done 1 prod %h",
               done, prod_hi, prod_lo, ref_prod(a, b));
    end
    start = 1'b1;
    src1  = 32'd0;
    src2  = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_restart got busy %b done %b want busy 1 done 0", busy, done);
    end
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 33 || {prod_hi, prod_lo} !== 64'h0) begin
      errors++; $display("FAIL b2b_second got %h_%h at cycle %0d want 0 at cycle 33", prod_hi, prod_lo, cyc);
    end
  endtask

  task automatic test_start_held;
    logic [31:0] a;
    logic [31:0] b;
    int cyc;
    int bcnt;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a    = $urandom;
      b    = $urandom;
      src1 = a;
      src2 = b;
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(cyc, bcnt);
    checks++;
    if (cyc !== 33 || {prod_hi, prod_lo} !== ref_prod(a, b)) begin
      errors++;
      $display("FAIL held_start got %h_%h at cycle %0d want %h at cycle 33",
               prod_hi, prod_lo, cyc, ref_prod(a, b));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_basic;
    test_products;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    test_start_held;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
